// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin arbiter sharing one LCD character-write path, with a read_done watchdog.
module lcd_write_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         LCD_data,
    output logic                      ReadPulse,
    input  logic                      read_done,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RELEASE = 2'd2} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   lcd_q;
    logic                rp_q;
    logic [1:0]          gid_q;
    logic                busy_q;
    logic                terr_q;
    logic [1:0]          last_q;
    logic [WD_W-1:0]     wd_q;
    logic [1:0]          cand;
    logic [1:0]          win_d;
    logic                found;
    logic [DATA_W-1:0]   data_d;

    // Scan starts one past the last grant and wraps, giving round-robin order.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        cand  = (last_q == LAST_ID) ? 2'd0 : last_q + 2'd1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                win_d = cand;
                found = 1'b1;
            end
            cand = (cand == LAST_ID) ? 2'd0 : cand + 2'd1;
        end
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (2'(i) == win_d) data_d = req_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            lcd_q   <= '0;
            rp_q    <= 1'b0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            last_q  <= LAST_ID;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found && !read_done) begin
                        gid_q   <= win_d;
                        lcd_q   <= data_d;
                        rp_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        wd_q    <= '0;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    wd_q <= wd_q + 1'b1;
                    // read_done is tested first so a completion on the expiry cycle still acks.
                    if (read_done) begin
                        rp_q    <= 1'b0;
                        ack_q   <= ONE << gid_q;
                        last_q  <= gid_q;
                        state_q <= RELEASE;
                    end else if (wd_q == WD_MAX) begin
                        rp_q    <= 1'b0;
                        terr_q  <= 1'b1;
                        last_q  <= gid_q;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    lcd_q   <= '0;
                    rp_q    <= 1'b0;
                    gid_q   <= '0;
                    busy_q  <= 1'b0;
                    wd_q    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign LCD_data    = lcd_q;
    assign ReadPulse   = rp_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
endmodule
